// File: rtl/ap_ctrl_multi_to_bambu.sv
// rtl/ap_ctrl_multi_to_bambu.sv - ap_ctrl block handshake fanned out to NUM_CH Bambu kernels
//
// Purpose:
//   Accepts one ap_ctrl start, sends a one-cycle start pulse to every enabled
//   Bambu kernel, gathers their one-cycle done pulses in a sticky mask and
//   reports a single completion upstream with the run latency in cycles.
//   Any done pulse that cannot belong to the current run raises a sticky
//   error flag. It never alters the collected mask.
//
// Ports:
//   ap_clk        clock
//   ap_rstn       asynchronous active-low reset
//   ap_start      host start, held until ap_ready
//   ap_continue   host acknowledge of ap_done (only used when CHAIN_MODE=1)
//   ch_enable     per-channel enable, captured when a start is accepted
//   ap_done       run complete (pulse in hs mode, held until ap_continue in chain mode)
//   ap_ready      one-cycle pulse: inputs consumed
//   ap_idle       block idle and no start pending
//   bambu_start   one-cycle start pulse per channel
//   bambu_done    one-cycle done pulse per channel
//   run_cycles    saturating latency of the last completed run
//   err_spurious  sticky flag for unexpected done pulses

module ap_ctrl_multi_to_bambu #(
  parameter int NUM_CH     = 4,
  parameter int CHAIN_MODE = 0,
  parameter int CNT_W      = 32
) (
  input  logic              ap_clk,
  input  logic              ap_rstn,
  input  logic              ap_start,
  input  logic              ap_continue,
  input  logic [NUM_CH-1:0] ch_enable,
  output logic              ap_done,
  output logic              ap_ready,
  output logic              ap_idle,
  output logic [NUM_CH-1:0] bambu_start,
  input  logic [NUM_CH-1:0] bambu_done,
  output logic [CNT_W-1:0]  run_cycles,
  output logic              err_spurious
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t              r_state;
  logic [NUM_CH-1:0]   r_active_mask;
  logic [NUM_CH-1:0]   r_done_mask;
  logic [CNT_W-1:0]    r_counter;
  logic [NUM_CH-1:0]   r_bambu_start;
  logic                r_ap_done;
  logic                r_ap_ready;
  logic [CNT_W-1:0]    r_run_cycles;
  logic                r_err;

  state_t              w_state_nxt;
  logic [NUM_CH-1:0]   w_active_nxt;
  logic [NUM_CH-1:0]   w_done_mask_nxt;
  logic [CNT_W-1:0]    w_counter_nxt;
  logic [NUM_CH-1:0]   w_bambu_start_nxt;
  logic                w_ap_done_nxt;
  logic                w_ap_ready_nxt;
  logic [CNT_W-1:0]    w_run_cycles_nxt;
  logic                w_err_nxt;

  logic [NUM_CH-1:0]   w_hit;
  logic [NUM_CH-1:0]   w_mask_acc;
  logic                w_complete;
  logic                w_spurious;
  logic [CNT_W-1:0]    w_cnt_inc;

  // The done pulses of the current edge count toward completion, so the
  // last channel's pulse finishes the run on the same edge it is sampled.
  assign w_hit      = bambu_done & r_active_mask;
  assign w_mask_acc = r_done_mask | w_hit;
  assign w_complete = (w_mask_acc == r_active_mask);
  assign w_cnt_inc  = (r_counter == '1) ? r_counter : r_counter + CNT_W'(1);

  // Outside RUN every pulse is unexpected; inside RUN only a first pulse
  // from a started channel is legitimate.
  assign w_spurious = (r_state != S_RUN) ? (|bambu_done)
                    : ((|(bambu_done & ~r_active_mask)) | (|(bambu_done & r_done_mask)));

  always_comb begin
    w_state_nxt       = r_state;
    w_active_nxt      = r_active_mask;
    w_done_mask_nxt   = r_done_mask;
    w_counter_nxt     = r_counter;
    w_bambu_start_nxt = '0;
    w_ap_done_nxt     = 1'b0;
    w_ap_ready_nxt    = 1'b0;
    w_run_cycles_nxt  = r_run_cycles;
    w_err_nxt         = r_err | w_spurious;
    case (r_state)
      S_IDLE: begin
        if (ap_start) begin
          w_active_nxt      = ch_enable;
          w_bambu_start_nxt = ch_enable;
          w_done_mask_nxt   = '0;
          w_counter_nxt     = CNT_W'(1);
          w_state_nxt       = S_RUN;
        end
      end
      S_RUN: begin
        w_done_mask_nxt = w_mask_acc;
        w_counter_nxt   = w_cnt_inc;
        if (w_complete) begin
          w_run_cycles_nxt = r_counter;
          w_ap_done_nxt    = 1'b1;
          w_ap_ready_nxt   = 1'b1;
          w_state_nxt      = (CHAIN_MODE != 0) ? S_HOLD : S_IDLE;
        end
      end
      S_HOLD: begin
        w_ap_done_nxt = 1'b1;
        if (ap_continue) begin
          w_ap_done_nxt = 1'b0;
          w_state_nxt   = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rstn) begin
    if (!ap_rstn) begin
      r_state       <= S_IDLE;
      r_active_mask <= '0;
      r_done_mask   <= '0;
      r_counter     <= '0;
      r_bambu_start <= '0;
      r_ap_done     <= 1'b0;
      r_ap_ready    <= 1'b0;
      r_run_cycles  <= '0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_active_mask <= w_active_nxt;
      r_done_mask   <= w_done_mask_nxt;
      r_counter     <= w_counter_nxt;
      r_bambu_start <= w_bambu_start_nxt;
      r_ap_done     <= w_ap_done_nxt;
      r_ap_ready    <= w_ap_ready_nxt;
      r_run_cycles  <= w_run_cycles_nxt;
      r_err         <= w_err_nxt;
    end
  end

  assign ap_done      = r_ap_done;
  assign ap_ready     = r_ap_ready;
  assign ap_idle      = (r_state == S_IDLE) & ~ap_start;
  assign bambu_start  = r_bambu_start;
  assign run_cycles   = r_run_cycles;
  assign err_spurious = r_err;

endmodule

// File: tb/tb_ap_ctrl_multi_to_bambu.sv
// tb/tb_ap_ctrl_multi_to_bambu.sv - directed scoreboard bench for ap_ctrl_multi_to_bambu

module tb_ap_ctrl_multi_to_bambu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // hs instance: NUM_CH=4, CHAIN_MODE=0, CNT_W=32
  logic        h_rstn, h_start, h_cont;
  logic [3:0]  h_en, h_bdone, h_bstart;
  logic        h_done, h_ready, h_idle, h_err;
  logic [31:0] h_rc;

  // chain instance: NUM_CH=4, CHAIN_MODE=1, CNT_W=4
  logic        c_rstn, c_start, c_cont;
  logic [3:0]  c_en, c_bdone, c_bstart;
  logic        c_done, c_ready, c_idle, c_err;
  logic [3:0]  c_rc;

  ap_ctrl_multi_to_bambu #(.NUM_CH(4), .CHAIN_MODE(0), .CNT_W(32)) dut_hs (
    .ap_clk(clk), .ap_rstn(h_rstn), .ap_start(h_start), .ap_continue(h_cont),
    .ch_enable(h_en), .ap_done(h_done), .ap_ready(h_ready), .ap_idle(h_idle),
    .bambu_start(h_bstart), .bambu_done(h_bdone), .run_cycles(h_rc),
    .err_spurious(h_err)
  );

  ap_ctrl_multi_to_bambu #(.NUM_CH(4), .CHAIN_MODE(1), .CNT_W(4)) dut_ch (
    .ap_clk(clk), .ap_rstn(c_rstn), .ap_start(c_start), .ap_continue(c_cont),
    .ch_enable(c_en), .ap_done(c_done), .ap_ready(c_ready), .ap_idle(c_idle),
    .bambu_start(c_bstart), .bambu_done(c_bdone), .run_cycles(c_rc),
    .err_spurious(c_err)
  );

  typedef struct {
    int rc;
    int cyc;
  } exp_t;

  exp_t sb_h[$];
  exp_t sb_c[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  logic c_prev_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic pop_h();
    exp_t e;
    if (sb_h.size() == 0) begin
      check("hs_unexpected_done", 32'(sb_h.size()), 32'd1);
    end else begin
      e = sb_h.pop_front();
      check("hs_run_cycles", h_rc, 32'(e.rc));
      check("hs_done_cycle", 32'(cyc), 32'(e.cyc));
    end
  endtask

  task automatic pop_c();
    exp_t e;
    if (sb_c.size() == 0) begin
      check("ch_unexpected_done", 32'(sb_c.size()), 32'd1);
    end else begin
      e = sb_c.pop_front();
      check("ch_run_cycles", 32'(c_rc), 32'(e.rc));
      check("ch_done_cycle", 32'(cyc), 32'(e.cyc));
    end
  endtask

  task automatic chk_h(input logic [3:0] bs, input logic dn, input logic idle, input logic err);
    check("hs_bambu_start", 32'(h_bstart), 32'(bs));
    check("hs_ap_done", 32'(h_done), 32'(dn));
    check("hs_ap_ready", 32'(h_ready), 32'(dn));
    check("hs_ap_idle", 32'(h_idle), 32'(idle));
    check("hs_err_spurious", 32'(h_err), 32'(err));
    if (h_done) pop_h();
  endtask

  task automatic chk_c(input logic [3:0] bs, input logic dn, input logic rdy, input logic idle);
    check("ch_bambu_start", 32'(c_bstart), 32'(bs));
    check("ch_ap_done", 32'(c_done), 32'(dn));
    check("ch_ap_ready", 32'(c_ready), 32'(rdy));
    check("ch_ap_idle", 32'(c_idle), 32'(idle));
    check("ch_err_spurious", 32'(c_err), 32'd0);
    if (c_done && !c_prev_done) pop_c();
    c_prev_done = c_done;
  endtask

  initial begin
    h_rstn = 1'b0; h_start = 1'b1; h_cont = 1'b0; h_en = 4'hF; h_bdone = 4'h0;
    c_rstn = 1'b0; c_start = 1'b1; c_cont = 1'b0; c_en = 4'hF; c_bdone = 4'h0;

    // Reset state: all outputs low, ap_idle follows ~ap_start.
    #12;
    check("rst_hs_done", 32'(h_done), 32'd0);
    check("rst_hs_ready", 32'(h_ready), 32'd0);
    check("rst_hs_bstart", 32'(h_bstart), 32'd0);
    check("rst_hs_rc", h_rc, 32'd0);
    check("rst_hs_err", 32'(h_err), 32'd0);
    check("rst_hs_idle_start1", 32'(h_idle), 32'd0);
    check("rst_ch_done", 32'(c_done), 32'd0);
    check("rst_ch_idle_start1", 32'(c_idle), 32'd0);
    h_start = 1'b0; c_start = 1'b0;
    #1;
    check("rst_hs_idle_start0", 32'(h_idle), 32'd1);
    check("rst_ch_idle_start0", 32'(c_idle), 32'd1);
    h_rstn = 1'b1; c_rstn = 1'b1;
    tick();

    // Run 1 (hs): all four channels, dones at cycles 3,5,5,9; start held
    // through ap_ready so run 2 follows with no idle gap.
    cyc = 0;
    h_start = 1'b1; h_en = 4'hF;
    sb_h.push_back('{rc: 9, cyc: 10});
    for (int k = 1; k <= 10; k++) begin
      tick();
      h_bdone = {cyc == 9, cyc == 5, cyc == 5, cyc == 3};
      if (cyc == 10) h_en = 4'b0101;
      chk_h((cyc == 1) ? 4'hF : 4'h0, cyc == 10, 1'b0, 1'b0);
    end

    // Run 2 (hs, back-to-back): ch0/ch2 enabled, spurious ch1 done at 14.
    sb_h.push_back('{rc: 6, cyc: 17});
    for (int k = 11; k <= 18; k++) begin
      tick();
      h_bdone = {1'b0, cyc == 16, cyc == 14, cyc == 13};
      chk_h((cyc == 11) ? 4'b0101 : 4'h0, cyc == 17, cyc >= 17, cyc >= 15);
      h_start = 1'b0;
    end
    check("hs_sb_drained_1", 32'(sb_h.size()), 32'd0);

    // Zero enable: completes on the first RUN cycle.
    h_start = 1'b1; h_en = 4'h0;
    sb_h.push_back('{rc: 1, cyc: 20});
    tick();
    chk_h(4'h0, 1'b0, 1'b0, 1'b1);
    h_start = 1'b0;
    tick();
    chk_h(4'h0, 1'b1, 1'b1, 1'b1);
    check("hs_sb_drained_2", 32'(sb_h.size()), 32'd0);

    // Async reset in the middle of a RUN cycle.
    h_start = 1'b1; h_en = 4'hF;
    tick();
    chk_h(4'hF, 1'b0, 1'b0, 1'b1);
    h_start = 1'b0;
    #2;
    h_rstn = 1'b0;
    #1;
    check("arst_bstart", 32'(h_bstart), 32'd0);
    check("arst_rc", h_rc, 32'd0);
    check("arst_err", 32'(h_err), 32'd0);
    check("arst_idle", 32'(h_idle), 32'd1);
    #1;
    h_rstn = 1'b1;
    tick();
    h_bdone = 4'b0010;
    tick();
    h_bdone = 4'h0;
    check("stale_err", 32'(h_err), 32'd1);
    check("stale_done", 32'(h_done), 32'd0);
    tick();
    check("stale_done_2", 32'(h_done), 32'd0);
    check("stale_rc", h_rc, 32'd0);

    // Chain run A: continue high during RUN is ignored, then low 5 cycles.
    cyc = 0;
    c_start = 1'b1; c_en = 4'b0011; c_cont = 1'b1;
    sb_c.push_back('{rc: 4, cyc: 5});
    for (int k = 1; k <= 11; k++) begin
      tick();
      c_bdone = {2'b00, cyc == 4, cyc == 2};
      c_cont  = (cyc <= 4) || (cyc >= 10);
      chk_c((cyc == 1) ? 4'b0011 : 4'h0, (cyc >= 5) && (cyc <= 10), cyc == 5, cyc == 11);
      c_start = 1'b0;
    end

    // Chain run B: 20-cycle run saturates CNT_W=4; continue in first HOLD cycle.
    c_start = 1'b1; c_en = 4'b0001; c_cont = 1'b1;
    sb_c.push_back('{rc: 15, cyc: 32});
    for (int k = 12; k <= 33; k++) begin
      tick();
      c_bdone = {3'b000, cyc == 31};
      chk_c((cyc == 12) ? 4'b0001 : 4'h0, cyc == 32, cyc == 32, cyc == 33);
      c_start = 1'b0;
    end
    check("ch_sb_drained", 32'(sb_c.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
